gpu_operand_fetch: RTL and testbench

- Multi-thread operand decode and fetch unit.
- Accepts one instruction's two operand descriptors per handshake and resolves each operand by mode: immediate, register, or memory base+offset.
- Issues register-file reads and memory requests, then presents both resolved operands downstream.
- Sits between the thread scheduler/decoder and the ALU/issue stage.
- Generalises the earlier single-operand address-mode decoder: parametrised threads and widths, per-thread base registers, ready/valid handshakes, reserved-mode error reporting.

---
 rtl/gpu_operand_fetch.sv | 240 ++++++++++++++++++++++++
 tb/tb_gpu_operand_fetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_operand_fetch.sv
// gpu_operand_fetch
//   Multi-thread operand decode/fetch. Takes one instruction's two operand
//   descriptors per in_valid/in_ready handshake, resolves each operand in
//   turn (A, then B) as immediate, register-file read, or memory read at
//   base[thread] + offset, then presents both operands downstream on an
//   out_valid/out_ready handshake.
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_*                      descriptor input (thread, modes, fields)
//   base_we/base_thread/data  per-thread base register write port
//   rf_rd_*                   register-file read (data returns 1 cycle later)
//   mem_req_*/mem_resp_*      memory read request / response
//   out_*                     resolved operands, thread id, error flag

// One per-thread memory base register.
module gpu_of_base_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module gpu_operand_fetch #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int NUM_THREADS = 4,
  parameter int TID_W       = 2,
  parameter int REG_IDX_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TID_W-1:0]     in_thread,
  input  logic [1:0]           in_mode_a,
  input  logic [1:0]           in_mode_b,
  input  logic [DATA_W-1:0]    in_field_a,
  input  logic [DATA_W-1:0]    in_field_b,
  input  logic                 base_we,
  input  logic [TID_W-1:0]     base_thread,
  input  logic [ADDR_W-1:0]    base_data,
  output logic                 rf_rd_en,
  output logic [TID_W-1:0]     rf_rd_thread,
  output logic [REG_IDX_W-1:0] rf_rd_idx,
  input  logic [DATA_W-1:0]    rf_rd_data,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ADDR_W-1:0]    mem_req_addr,
  input  logic                 mem_resp_valid,
  input  logic [DATA_W-1:0]    mem_resp_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TID_W-1:0]     out_thread,
  output logic [DATA_W-1:0]    out_op_a,
  output logic [DATA_W-1:0]    out_op_b,
  output logic                 out_err
);

  typedef enum logic [2:0] {
    IDLE, OP_A, OP_B, RF_WAIT, MEM_REQ, MEM_WAIT, OUT
  } state_t;

  state_t state, nxt;

  // latched descriptor
  logic [TID_W-1:0]  thr;
  logic [1:0]        mode_a, mode_b;
  logic [DATA_W-1:0] field_a, field_b;
  logic              cur_b;   // 0: resolving operand A, 1: operand B
  logic              err;
  logic [DATA_W-1:0] op_a, op_b;
  logic [ADDR_W-1:0] addr_q;

  // base registers, one instance per thread; writes to nonexistent
  // threads match no instance and are dropped
  logic [NUM_THREADS-1:0][ADDR_W-1:0] base_q;

  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_base
    gpu_of_base_reg #(.W(ADDR_W)) u_base (
      .clk (clk),
      .rst (rst),
      .we  (base_we && (base_thread == TID_W'(g))),
      .d   (base_data),
      .q   (base_q[g])
    );
  end

  // thread legality and base lookup by match, so non-power-of-2 thread
  // counts need no out-of-range index
  logic              thread_ok;
  logic [ADDR_W-1:0] base_sel;
  always_comb begin
    thread_ok = 1'b0;
    base_sel  = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (thr == TID_W'(i)) begin
        thread_ok = 1'b1;
        base_sel  = base_q[i];
      end
    end
  end

  logic [1:0]        cur_mode;
  logic [DATA_W-1:0] cur_field;
  assign cur_mode  = cur_b ? mode_b  : mode_a;
  assign cur_field = cur_b ? field_b : field_a;

  // control strobes
  logic              ld_in, op_we, err_set, err_clr, addr_ld, adv;
  logic [DATA_W-1:0] op_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt           = state;
    in_ready      = 1'b0;
    rf_rd_en      = 1'b0;
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;
    ld_in         = 1'b0;
    op_we         = 1'b0;
    op_val        = '0;
    err_set       = 1'b0;
    err_clr       = 1'b0;
    addr_ld       = 1'b0;
    adv           = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_in = 1'b1;
          nxt   = OP_A;
        end
      end
      OP_A, OP_B: begin
        if (cur_mode == 2'd3 || !thread_ok) begin
          // no RF/memory side effects for an illegal operand
          op_we   = 1'b1;
          err_set = 1'b1;
          adv     = 1'b1;
        end else begin
          case (cur_mode)
            2'd0: begin
              op_we  = 1'b1;
              op_val = cur_field;
              adv    = 1'b1;
            end
            2'd1: begin
              rf_rd_en = 1'b1;
              nxt      = RF_WAIT;
            end
            default: begin
              addr_ld = 1'b1;
              nxt     = MEM_REQ;
            end
          endcase
        end
      end
      RF_WAIT: begin
        op_we  = 1'b1;
        op_val = rf_rd_data;
        adv    = 1'b1;
      end
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_resp_valid) begin
          op_we  = 1'b1;
          op_val = mem_resp_data;
          adv    = 1'b1;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          err_clr = 1'b1;
          nxt     = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
    if (adv) nxt = cur_b ? OUT : OP_B;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr     <= '0;
      mode_a  <= '0;
      mode_b  <= '0;
      field_a <= '0;
      field_b <= '0;
      cur_b   <= 1'b0;
      err     <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      addr_q  <= '0;
    end else begin
      if (ld_in) begin
        thr     <= in_thread;
        mode_a  <= in_mode_a;
        mode_b  <= in_mode_b;
        field_a <= in_field_a;
        field_b <= in_field_b;
        cur_b   <= 1'b0;
      end else if (adv && !cur_b) begin
        cur_b <= 1'b1;
      end
      if (op_we) begin
        if (cur_b) op_b <= op_val;
        else       op_a <= op_val;
      end
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      // base_q still holds its pre-write value in a same-cycle write
      if (addr_ld) addr_q <= base_sel + cur_field[ADDR_W-1:0];
    end
  end

  assign rf_rd_thread = rf_rd_en ? thr : '0;
  assign rf_rd_idx    = rf_rd_en ? cur_field[REG_IDX_W-1:0] : '0;
  assign mem_req_addr = addr_q;
  assign out_thread   = thr;
  assign out_op_a     = op_a;
  assign out_op_b     = op_b;
  assign out_err      = err;

endmodule

// File: tb/tb_gpu_operand_fetch.sv
// Directed bench for gpu_operand_fetch: immediate, register, memory with
// wrap and stall, base-write race, reserved mode with backpressure, and
// reset in the middle of a memory read.
module tb_gpu_operand_fetch;
  logic        clk = 0;
  logic        rst = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [1:0]  in_thread = 0;
  logic [1:0]  in_mode_a = 0, in_mode_b = 0;
  logic [31:0] in_field_a = 0, in_field_b = 0;
  logic        base_we = 0;
  logic [1:0]  base_thread = 0;
  logic [15:0] base_data = 0;
  logic        rf_rd_en;
  logic [1:0]  rf_rd_thread;
  logic [3:0]  rf_rd_idx;
  logic [31:0] rf_rd_data = 0;
  logic        mem_req_valid;
  logic        mem_req_ready = 0;
  logic [15:0] mem_req_addr;
  logic        mem_resp_valid = 0;
  logic [31:0] mem_resp_data = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [1:0]  out_thread;
  logic [31:0] out_op_a, out_op_b;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  gpu_operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_thread(in_thread),
    .in_mode_a(in_mode_a), .in_mode_b(in_mode_b),
    .in_field_a(in_field_a), .in_field_b(in_field_b),
    .base_we(base_we), .base_thread(base_thread), .base_data(base_data),
    .rf_rd_en(rf_rd_en), .rf_rd_thread(rf_rd_thread), .rf_rd_idx(rf_rd_idx),
    .rf_rd_data(rf_rd_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_thread(out_thread),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_base(input logic [1:0] t, input logic [15:0] d);
    base_we = 1; base_thread = t; base_data = d;
    tick();
    base_we = 0;
  endtask

  // handshake happens at the edge inside; returns in cycle T+1
  task automatic issue(input logic [1:0] t, input logic [1:0] ma,
                       input logic [31:0] fa, input logic [1:0] mb,
                       input logic [31:0] fb);
    in_thread = t; in_mode_a = ma; in_field_a = fa;
    in_mode_b = mb; in_field_b = fb; in_valid = 1;
    tick();
    in_valid = 0;
  endtask

  task automatic wait_out(input int start, output int n);
    n = start;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic accept();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if ({rf_rd_en, rf_rd_thread, rf_rd_idx, mem_req_valid, mem_req_addr} !== 24'h0) begin
      errors++; $display("FAIL reset_req_outs got %h want 0", {rf_rd_en, rf_rd_thread, rf_rd_idx, mem_req_valid, mem_req_addr}); end
    checks++; if ({out_valid, out_thread, out_op_a, out_op_b, out_err} !== 68'h0) begin
      errors++; $display("FAIL reset_out_outs got %h want 0", {out_valid, out_thread, out_op_a, out_op_b, out_err}); end
    rst = 0;
    tick();
  endtask

  task automatic test_imm();
    int n;
    issue(2'd1, 2'd0, 32'h1234, 2'd0, 32'hFFFF_FFFF);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL imm_busy got %b want 0", in_ready); end
    wait_out(1, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL imm_latency got %0d want 3", n); end
    checks++; if (out_op_a !== 32'h1234) begin errors++; $display("FAIL imm_op_a got %h want 00001234", out_op_a); end
    checks++; if (out_op_b !== 32'hFFFF_FFFF) begin errors++; $display("FAIL imm_op_b got %h want ffffffff", out_op_b); end
    checks++; if (out_err !== 1'b0 || out_thread !== 2'd1) begin
      errors++; $display("FAIL imm_err_thr got %b/%0d want 0/1", out_err, out_thread); end
    accept();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL imm_return got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_reg();
    int n;
    issue(2'd2, 2'd1, 32'h5, 2'd0, 32'h7);
    checks++; if (rf_rd_en !== 1'b1 || rf_rd_thread !== 2'd2 || rf_rd_idx !== 4'd5) begin
      errors++; $display("FAIL reg_strobe got en=%b thr=%0d idx=%0d want 1/2/5", rf_rd_en, rf_rd_thread, rf_rd_idx); end
    rf_rd_data = 32'hCAFE;
    tick();
    checks++; if (rf_rd_en !== 1'b0) begin errors++; $display("FAIL reg_one_cycle got %b want 0", rf_rd_en); end
    tick();
    rf_rd_data = 32'h0;
    wait_out(3, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL reg_latency got %0d want 4", n); end
    checks++; if (out_op_a !== 32'hCAFE || out_op_b !== 32'h7) begin
      errors++; $display("FAIL reg_ops got %h/%h want 0000cafe/00000007", out_op_a, out_op_b); end
    accept();
  endtask

  task automatic test_mem_wrap_stall();
    int c, n;
    write_base(2'd3, 16'hFFF0);
    issue(2'd3, 2'd0, 32'h11, 2'd2, 32'h20);
    c = 1;
    while (!mem_req_valid && c < 40) begin tick(); c++; end
    checks++; if (c !== 3) begin errors++; $display("FAIL mem_req_cycle got %0d want 3", c); end
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_req_ready = 1;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 16'h0010) begin
        errors++; $display("FAIL mem_stall%0d got vld=%b addr=%h want 1/0010", k, mem_req_valid, mem_req_addr); end
      tick(); c++;
    end
    mem_req_ready = 0;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL mem_drop got %b want 0", mem_req_valid); end
    tick(); c++;
    mem_resp_valid = 1; mem_resp_data = 32'hBEEF;
    tick(); c++;
    mem_resp_valid = 0; mem_resp_data = 0;
    wait_out(c, n);
    checks++; if (n !== 9) begin errors++; $display("FAIL mem_latency got %0d want 9", n); end
    checks++; if (out_op_a !== 32'h11 || out_op_b !== 32'hBEEF || out_thread !== 2'd3) begin
      errors++; $display("FAIL mem_ops got %h/%h/%0d want 00000011/0000beef/3", out_op_a, out_op_b, out_thread); end
    accept();
  endtask

  task automatic test_base_race();
    int n;
    write_base(2'd0, 16'h0040);
    issue(2'd0, 2'd2, 32'h4, 2'd0, 32'h0);
    // OP_A computes the address this cycle while base[0] is overwritten
    base_we = 1; base_thread = 2'd0; base_data = 16'h0100;
    tick();
    base_we = 0;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 16'h0044) begin
      errors++; $display("FAIL race_addr got vld=%b addr=%h want 1/0044", mem_req_valid, mem_req_addr); end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    mem_resp_valid = 1; mem_resp_data = 32'h55;
    tick();
    mem_resp_valid = 0;
    wait_out(4, n);
    checks++; if (n !== 5 || out_op_a !== 32'h55) begin
      errors++; $display("FAIL race_result got n=%0d op_a=%h want 5/00000055", n, out_op_a); end
    accept();
    issue(2'd0, 2'd2, 32'h4, 2'd0, 32'h0);
    tick();
    checks++; if (mem_req_addr !== 16'h0104) begin errors++; $display("FAIL race_newbase got %h want 0104", mem_req_addr); end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    mem_resp_valid = 1;
    tick();
    mem_resp_valid = 0;
    wait_out(4, n);
    accept();
  endtask

  task automatic test_reserved_backpressure();
    int n;
    issue(2'd1, 2'd3, 32'h99, 2'd0, 32'h77);
    checks++; if (rf_rd_en !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rsv_no_access got rf=%b mem=%b want 0/0", rf_rd_en, mem_req_valid); end
    wait_out(1, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL rsv_latency got %0d want 3", n); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_op_a !== 32'h0 || out_op_b !== 32'h77
                    || out_err !== 1'b1 || out_thread !== 2'd1) begin
        errors++; $display("FAIL rsv_hold%0d got vld=%b rdy=%b a=%h b=%h err=%b thr=%0d want 1/0/0/77/1/1",
                           k, out_valid, in_ready, out_op_a, out_op_b, out_err, out_thread); end
      tick();
    end
    accept();
    issue(2'd0, 2'd0, 32'h1, 2'd0, 32'h2);
    wait_out(1, n);
    checks++; if (out_err !== 1'b0 || out_op_a !== 32'h1) begin
      errors++; $display("FAIL rsv_err_clear got err=%b a=%h want 0/00000001", out_err, out_op_a); end
    accept();
  endtask

  task automatic test_reset_mid_mem();
    int seen;
    issue(2'd3, 2'd2, 32'h8, 2'd0, 32'h0);
    tick();
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    // now waiting for the response; reset asynchronously mid-cycle
    #2 rst = 1;
    #1;
    checks++; if (in_ready !== 1'b1 || mem_req_valid !== 1'b0 || mem_req_addr !== 16'h0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_async got rdy=%b mreq=%b addr=%h vld=%b want 1/0/0000/0",
                         in_ready, mem_req_valid, mem_req_addr, out_valid); end
    tick();
    rst = 0;
    mem_resp_valid = 1; mem_resp_data = 32'hDEAD;
    tick();
    mem_resp_valid = 0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid || !in_ready) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_stray got %0d busy cycles want 0", seen); end
    checks++; if ({out_op_a, out_op_b, out_err, out_thread} !== 67'h0) begin
      errors++; $display("FAIL rst_outs got %h want 0", {out_op_a, out_op_b, out_err, out_thread}); end
    // base[3] was 0xFFF0 before reset; it must read back as 0
    issue(2'd3, 2'd2, 32'h20, 2'd0, 32'h0);
    tick();
    checks++; if (mem_req_addr !== 16'h0020) begin errors++; $display("FAIL rst_base got %h want 0020", mem_req_addr); end
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_imm();
    test_reg();
    test_mem_wrap_stall();
    test_base_race();
    test_reserved_backpressure();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
